// File: rtl/ic_fifo_xbar_if.sv
// Handshake bundle for ic_fifo_xbar: source offers, destination selects, FIFO heads.
// Flat vectors; port i occupies [i*W +: W] / [i*A +: A].
interface ic_fifo_xbar_if #(
    parameter int N = 8,
    parameter int W = 128
);
    localparam int A = $clog2(N);

    logic [N*A-1:0] recv_from;
    logic [N-1:0]   send_en;
    logic [N*W-1:0] send_word;
    logic [N-1:0]   send_rdy;
    logic [N-1:0]   recv_en;
    logic [N*W-1:0] recv_word;
    logic [N-1:0]   recv_rdy;
    logic [15:0]    drop_cnt;

    modport master (
        output recv_from, send_en, send_word, recv_rdy,
        input  send_rdy, recv_en, recv_word, drop_cnt
    );

    modport slave (
        input  recv_from, send_en, send_word, recv_rdy,
        output send_rdy, recv_en, recv_word, drop_cnt
    );
endinterface

// File: rtl/ic_fifo_xbar.sv
// N-port crossbar with a DEPTH-entry FIFO per destination and atomic multicast pushes.
// Optional unlistened-word counter built only with IC_FIFO_XBAR_DROPCNT_EN defined.
module ic_fifo_xbar_lane #(
    parameter int W     = 128,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         rdy,
    output logic         full,
    output logic         vld,
    output logic [W-1:0] word
);
    localparam int P = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [P-1:0]            wp, rp;
    logic [P:0]              cnt;
    logic                    do_push, do_pop;

    assign full    = (cnt == (P+1)'(DEPTH));
    assign vld     = (cnt != '0);
    // full already blocks the source; gating here keeps the lane safe on its own
    assign do_push = push & ~full;
    assign do_pop  = vld & rdy;
    assign word    = mem[rp];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '0;
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else if (clr) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= wdata;
                wp      <= wp + P'(1);
            end
            if (do_pop)
                rp <= rp + P'(1);
            if (do_push && !do_pop)
                cnt <= cnt + (P+1)'(1);
            else if (!do_push && do_pop)
                cnt <= cnt - (P+1)'(1);
        end
    end
endmodule

module ic_fifo_xbar #(
    parameter int N     = 8,
    parameter int W     = 128,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    ic_fifo_xbar_if.slave  bus
);
    localparam int A = $clog2(N);

    logic [N-1:0][N-1:0] lis;   // lis[i][d]: destination d listens to source i
    logic [N-1:0]        full, vld, rdy, acc, push;
    logic [N-1:0][W-1:0] wdata, rword;

    always_comb begin
        for (int i = 0; i < N; i++)
            for (int d = 0; d < N; d++)
                lis[i][d] = (bus.recv_from[d*A +: A] == A'(i));
    end

    // Readiness looks only at registered full flags, so no path from recv_rdy or send_en
    always_comb begin
        for (int i = 0; i < N; i++)
            rdy[i] = ~|(lis[i] & full);
        acc = bus.send_en & rdy;
    end

    // Out-of-range selections match no source and leave push low
    always_comb begin
        for (int d = 0; d < N; d++) begin
            push[d]  = 1'b0;
            wdata[d] = '0;
            for (int i = 0; i < N; i++) begin
                if (lis[i][d]) begin
                    push[d]  = acc[i];
                    wdata[d] = bus.send_word[i*W +: W];
                end
            end
        end
    end

    for (genvar d = 0; d < N; d++) begin : g_lane
        ic_fifo_xbar_lane #(.W(W), .DEPTH(DEPTH)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr),
            .push  (push[d]),
            .wdata (wdata[d]),
            .rdy   (bus.recv_rdy[d]),
            .full  (full[d]),
            .vld   (vld[d]),
            .word  (rword[d])
        );
    end

    assign bus.send_rdy  = rdy;
    assign bus.recv_en   = vld;
    assign bus.recv_word = rword;

`ifdef IC_FIFO_XBAR_DROPCNT_EN
    localparam int CW = $clog2(N + 1);

    logic [CW-1:0] n_drop;
    logic [16:0]   drop_sum;
    logic [15:0]   drop_q;

    always_comb begin
        n_drop = '0;
        for (int i = 0; i < N; i++)
            if (bus.send_en[i] && !(|lis[i]))
                n_drop = n_drop + CW'(1);
        drop_sum = {1'b0, drop_q} + 17'(n_drop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            drop_q <= '0;
        else if (!clr)
            drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    assign bus.drop_cnt = drop_q;
`else
    assign bus.drop_cnt = '0;
`endif
endmodule

// File: tb/tb_ic_fifo_xbar.sv
// Randomized bench for ic_fifo_xbar against a queue-per-destination model,
// with directed segments pinning latency, multicast backpressure, clr and drop count.
module tb_ic_fifo_xbar;
    localparam int N     = 8;
    localparam int W     = 128;
    localparam int DEPTH = 4;
    localparam int A     = $clog2(N);

    logic clk = 1'b0;
    logic rst;
    logic clr;

    ic_fifo_xbar_if #(.N(N), .W(W)) bus ();

    ic_fifo_xbar #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] mq [N][$];
    logic [15:0]  mdrop = '0;
    logic [N-1:0] mok, er;
    int           nl;

`ifdef IC_FIFO_XBAR_DROPCNT_EN
    localparam int DROP_EN = 1;
`else
    localparam int DROP_EN = 0;
`endif

    task automatic chk(string nm, logic [W-1:0] got, logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
        end
    endtask

    function automatic int rf(int d);
        return int'(bus.recv_from[d*A +: A]);
    endfunction

    function automatic logic exp_rdy(int i);
        logic r = 1'b1;
        for (int d = 0; d < N; d++)
            if (rf(d) == i && mq[d].size() >= DEPTH) r = 1'b0;
        return r;
    endfunction

    // Model: queues per destination, pops decided on pre-edge occupancy
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < N; d++) mq[d].delete();
            mdrop = '0;
        end else if (clr) begin
            for (int d = 0; d < N; d++) mq[d].delete();
        end else begin
            for (int i = 0; i < N; i++) mok[i] = exp_rdy(i);
            for (int d = 0; d < N; d++)
                if (mq[d].size() > 0 && bus.recv_rdy[d]) void'(mq[d].pop_front());
            for (int i = 0; i < N; i++) begin
                if (bus.send_en[i]) begin
                    nl = 0;
                    for (int d = 0; d < N; d++) begin
                        if (rf(d) == i) begin
                            nl++;
                            if (mok[i]) mq[d].push_back(bus.send_word[i*W +: W]);
                        end
                    end
                    if (nl == 0 && DROP_EN != 0 && mdrop != 16'hFFFF) mdrop = mdrop + 16'd1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) er[i] = exp_rdy(i);
        chk("send_rdy", W'(bus.send_rdy), W'(er));
        for (int d = 0; d < N; d++) begin
            chk($sformatf("recv_en[%0d]", d), W'(bus.recv_en[d]), W'(mq[d].size() > 0));
            if (mq[d].size() > 0)
                chk($sformatf("recv_word[%0d]", d), bus.recv_word[d*W +: W], mq[d][0]);
        end
        chk("drop_cnt", W'(bus.drop_cnt), W'(mdrop));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rf(int d, int s);
        bus.recv_from[d*A +: A] = A'(s);
    endtask

    task automatic idle_inputs();
        bus.send_en  = '0;
        bus.recv_rdy = '0;
        clr          = 1'b0;
    endtask

    logic [15:0] exp5;

    initial begin
        rst = 1'b1;
        idle_inputs();
        bus.recv_from = '0;
        bus.send_word = '0;
        exp5 = (DROP_EN != 0) ? 16'd5 : 16'd0;
        repeat (2) tick();
        chk("rst_send_rdy", W'(bus.send_rdy), W'({N{1'b1}}));
        chk("rst_recv_en", W'(bus.recv_en), '0);
        chk("rst_drop", W'(bus.drop_cnt), '0);
        rst = 1'b0;
        tick();

        // unicast latency and hold
        set_rf(5, 2);
        bus.send_word[2*W +: W] = 128'hA5A5;
        bus.send_en[2] = 1'b1;
        tick();
        bus.send_en = '0;
        chk("uni_en", W'(bus.recv_en[5]), W'(1));
        chk("uni_word", bus.recv_word[5*W +: W], 128'hA5A5);
        repeat (2) tick();
        chk("uni_hold", bus.recv_word[5*W +: W], 128'hA5A5);
        bus.recv_rdy[5] = 1'b1;
        tick();
        chk("uni_pop", W'(bus.recv_en[5]), W'(0));
        idle_inputs();

        // multicast 4 -> {0,1}, destination 1 stalled
        bus.recv_from = '0;
        set_rf(0, 4);
        set_rf(1, 4);
        bus.recv_rdy[0] = 1'b1;
        bus.send_en[4]  = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            bus.send_word[4*W +: W] = W'(k);
            tick();
        end
        bus.send_word[4*W +: W] = W'(5);
        chk("mc_blocked", W'(bus.send_rdy[4]), W'(0));
        chk("mc_d0_last", bus.recv_word[0*W +: W], W'(4));
        chk("mc_d1_head", bus.recv_word[1*W +: W], W'(1));
        tick();
        chk("mc_d0_drained", W'(bus.recv_en[0]), W'(0));
        bus.recv_rdy[1] = 1'b1;
        tick();
        chk("full_pop_rdy", W'(bus.send_rdy[4]), W'(1));
        chk("full_pop_head", bus.recv_word[1*W +: W], W'(2));
        tick();
        bus.send_en = '0;
        chk("mc_resume", bus.recv_word[1*W +: W], W'(3));
        bus.recv_rdy = '1;
        repeat (6) tick();
        idle_inputs();

        // drop count then clr with all FIFOs holding 2 words
        bus.recv_from = '0;
        bus.send_en[3] = 1'b1;
        repeat (5) tick();
        bus.send_en = '0;
        chk("drop5", W'(bus.drop_cnt), W'(exp5));
        bus.send_en[0] = 1'b1;
        bus.send_word[0*W +: W] = 128'h77;
        repeat (2) tick();
        chk("half_full", W'(bus.recv_en), W'({N{1'b1}}));
        clr = 1'b1;
        tick();
        idle_inputs();
        chk("clr_empty", W'(bus.recv_en), '0);
        chk("clr_drop", W'(bus.drop_cnt), W'(exp5));

        // randomized traffic with reselection, clr and one mid-traffic reset
        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < N; d++)
                if ($urandom_range(15) == 0) set_rf(d, int'($urandom_range(N - 1)));
            bus.send_en = N'($urandom);
            for (int i = 0; i < N; i++)
                bus.send_word[i*W +: W] = {$urandom, $urandom, $urandom, $urandom};
            for (int d = 0; d < N; d++)
                bus.recv_rdy[d] = ($urandom_range(3) < ((c / 200) % 3) + 1);
            clr = ($urandom_range(63) == 0);
            if (c == 1500) begin
                #2 rst = 1'b1;
                #1;
                chk("mid_rst_en", W'(bus.recv_en), '0);
                chk("mid_rst_word", W'(bus.recv_word == '0), W'(1));
                tick();
                rst = 1'b0;
                #1;
                chk("post_rst_rdy", W'(bus.send_rdy), W'({N{1'b1}}));
            end
            tick();
        end
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ic_fifo_xbar.md
Name: ic_fifo_xbar

Overview:
- Next-generation MVU-array interconnect. Parametrised N-port crossbar with per-destination FIFO buffering and valid/ready backpressure.
- Each destination MVU selects one source MVU, and several destinations may select the same source (multicast).
- Sits between the MVU-array read-interconnect words (rdi side) and write-interconnect words (wri side).
- Replaces the unbuffered single-cycle interconnect with one that tolerates stalled receivers.

Parameters:
N, 8, number of ports (MVUs); minimum 2
W, 128, word width in bits (2*b)
DEPTH, 4, entries per destination FIFO; power of two, minimum 2
A, $clog2(N), localparam: source-select width
P, $clog2(DEPTH), localparam: FIFO pointer width

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  asynchronous active-high reset
clr  in  1  synchronous flush of all FIFOs
recv_from  in  N*A  field d = source index selected by destination d
send_en  in  N  source i offers send_word[i]
send_word  in  N*W  source words, port i at [i*W +: W]
send_rdy  out  N  source i word accepted this cycle if send_en[i]
recv_en  out  N  destination d FIFO head valid
recv_word  out  N*W  destination d FIFO head
recv_rdy  in  N  destination d consumes head this cycle
drop_cnt  out  16  words accepted with no listener (see Optional Feature)

Behaviour:
- Reset (rst=1, async): all FIFOs empty, pointers 0, recv_en=0, recv_word=0, drop_cnt=0. send_rdy is combinational and therefore all-ones while rst=1, but no push occurs during reset.
- Listener set L(i) = {d : recv_from[d]==i}.
- full[d]: FIFO occupancy == DEPTH.
- send_rdy[i] = AND of !full[d] over d in L(i); equals 1 when L(i) is empty. It is purely a function of registered full flags and recv_from, with no combinational path from recv_rdy or send_en.
- Push: when send_en[i] & send_rdy[i], write send_word[i] into every FIFO d in L(i) in the same cycle (atomic multicast). There is no partial delivery.
- Pop: when recv_en[d] & recv_rdy[d], advance head of FIFO d. recv_rdy while empty is ignored.
- Simultaneous push and pop on the same FIFO:
  - Occupancy is unchanged.
  - Allowed when not full.
  - When full, the push is blocked (send_rdy already 0) even if popping that cycle. Pop still occurs.
- Latency: a word pushed at edge k appears on recv_word/recv_en after edge k (visible in cycle k+1). Empty→valid latency is 1 cycle. No bypass.
- recv_word is driven from FIFO storage at the head pointer and is stable while recv_en=1 and no pop occurs.
- Pointers wrap modulo DEPTH. Occupancy is held in a P+1-bit counter.
- recv_from may change at any cycle:
  - Words already buffered stay in order and are delivered.
  - Subsequent pushes follow the new selection from that same cycle.
- Out-of-range recv_from values (≥N, when N is not a power of two): that destination has no source and never receives.
- Self-selection (recv_from[d]==d) is legal: data loops back to port d.
- clr=1 (sync): all FIFOs empty at the next edge. clr overrides any push/pop in that cycle, so words offered that cycle are discarded even though send_rdy may read 1. drop_cnt is unaffected by clr.
- Per-destination order is FIFO. Across destinations, multicast copies occupy the same relative order as the source sent them.

Optional Feature:
- Macro: IC_FIFO_XBAR_DROPCNT_EN.
- Defined: drop_cnt increments by the number of sources i with send_en[i]=1 and L(i) empty in a cycle, excluding clr cycles. It saturates at 16'hFFFF and resets to 0 only on rst.
- Undefined: no counter logic is built and drop_cnt is tied to 0.
- Port list is identical in both builds.

Test Plan:
- Reset mid-traffic: fill FIFO 3 with 2 words, assert rst asynchronously between edges → recv_en=0, recv_word=0 immediately; after release, send_rdy all-ones and the first push appears 1 cycle later.
- Unicast latency: N=8, recv_from[5]=2, send_word[2]=128'hA5A5 pulsed 1 cycle → recv_en[5]=1, recv_word[5]=128'hA5A5 the next cycle, held until recv_rdy[5]=1.
- Multicast backpressure: recv_from[0]=recv_from[1]=4, recv_rdy[0]=1, recv_rdy[1]=0, send_en[4] held with incrementing words 1,2,3…
  - After DEPTH=4 accepts, send_rdy[4]=0.
  - Destination 0 has drained 1..4 and destination 1 holds 1..4.
  - Raising recv_rdy[1] resumes sending at word 5.
- Full with simultaneous pop: FIFO 2 full, recv_rdy[2]=1, send_en to its source → send_rdy=0 that cycle; occupancy 3 after the edge; the push is accepted the following cycle.
- Wrap and reselect: push 10 words through destination 6 with DEPTH=4, then switch recv_from[6] from 1 to 7 while 2 words are buffered → the output order is the 2 old words, then words from source 7, with no loss.
- clr and drop count (macro defined): no listener on source 3, send_en[3]=1 for 5 cycles → drop_cnt=5. Then clr with all FIFOs half full → all recv_en=0 next cycle and drop_cnt still 5. With the macro undefined, drop_cnt stays 0.
